// File: rtl/branch_predictor_btb.sv
// Branch predictor: tag-checked BTB with 2-bit saturating counters, combinational IF lookup.
// Optional performance counters are built when BP_PERF_CNT_EN is defined.
module branch_predictor_btb #(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned PC_W      = 32,
    parameter logic [1:0]  CTR_INIT  = 2'b01,
    parameter logic [1:0]  ALLOC_CTR = 2'b10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_next_pc,
    input  logic            update_en,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_taken,
    input  logic [PC_W-1:0] update_target,
    input  logic            update_pred_taken,
    input  logic [PC_W-1:0] update_pred_target,
    output logic            mispredict,
`ifdef BP_PERF_CNT_EN
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts,
    output logic [31:0]     perf_btb_hits,
`endif
    input  logic            bp_clear
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       up_ctr;
    logic [1:0]       ctr_inc;
    logic [1:0]       ctr_dec;
    logic             unused_pc_lsbs;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[PC_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^update_pc[1:0];

    // IF-stage lookup; reads the pre-update array contents (no bypass)
    assign pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken   = pred_hit && ctr_q[lk_idx][1];
    assign pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + PC_W'(4);

    assign mispredict = update_en &&
                        ((update_taken != update_pred_taken) ||
                         (update_taken && (update_pred_target != update_target)));

    assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr  = ctr_q[up_idx];
    assign ctr_inc = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
    assign ctr_dec = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;

    // Entry state: clear wins over a concurrent update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else if (bp_clear) begin
            valid_q <= '0;
        end else if (update_en) begin
            if (up_hit) begin
                if (update_taken) begin
                    ctr_q[up_idx]    <= ctr_inc;
                    target_q[up_idx] <= update_target;
                end else begin
                    ctr_q[up_idx] <= ctr_dec;
                end
            end else if (update_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
                ctr_q[up_idx]    <= ALLOC_CTR;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    // Free-running event counters, frozen during a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
            perf_btb_hits    <= '0;
        end else if (!bp_clear) begin
            if (update_en)  perf_branches    <= perf_branches + 32'd1;
            if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
            if (pred_hit)   perf_btb_hits    <= perf_btb_hits + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: stimulus queues expected outputs, a monitor compares them.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_pred_taken;
    logic [31:0] update_pred_target;
    logic        mispredict;
    logic        bp_clear;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
    logic [31:0] perf_btb_hits;
`endif

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic        tk;
        logic [31:0] npc;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    branch_predictor_btb dut (
        .clk                (clk),
        .reset              (reset),
        .lookup_pc          (lookup_pc),
        .pred_hit           (pred_hit),
        .pred_taken         (pred_taken),
        .pred_next_pc       (pred_next_pc),
        .update_en          (update_en),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_target      (update_target),
        .update_pred_taken  (update_pred_taken),
        .update_pred_target (update_pred_target),
        .mispredict         (mispredict),
`ifdef BP_PERF_CNT_EN
        .perf_branches      (perf_branches),
        .perf_mispredicts   (perf_mispredicts),
        .perf_btb_hits      (perf_btb_hits),
`endif
        .bp_clear           (bp_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: outputs are valid mid-cycle, after inputs settled past the rising edge
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".hit"}, 32'(pred_hit), 32'(e.hit));
                chk({e.name, ".taken"}, 32'(pred_taken), 32'(e.tk));
                chk({e.name, ".next_pc"}, pred_next_pc, e.npc);
                chk({e.name, ".mispredict"}, 32'(mispredict), 32'(e.mis));
            end
        end
    end

    task automatic drive(input logic [31:0] lpc, input logic ue, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic upt,
                         input logic [31:0] uptgt, input logic clr);
        lookup_pc          = lpc;
        update_en          = ue;
        update_pc          = upc;
        update_taken       = ut;
        update_target      = utgt;
        update_pred_taken  = upt;
        update_pred_target = uptgt;
        bp_clear           = clr;
    endtask

    task automatic expect_out(input string name, input logic hit, input logic tk,
                              input logic [31:0] npc, input logic mis);
        exp_t e;
        e.name = name;
        e.hit  = hit;
        e.tk   = tk;
        e.npc  = npc;
        e.mis  = mis;
        exp_q.push_back(e);
    endtask

    task automatic step(input string name, input logic [31:0] lpc, input logic ue,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input logic upt, input logic [31:0] uptgt, input logic clr,
                        input logic hit, input logic tk, input logic [31:0] npc,
                        input logic mis);
        @(posedge clk);
        #1;
        drive(lpc, ue, upc, ut, utgt, upt, uptgt, clr);
        expect_out(name, hit, tk, npc, mis);
    endtask

    initial begin
        int budget;
        reset = 1'b0;
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        //    name          lookup        ue  upc           ut  target        upt uptgt     clr  hit tk npc          mis
        step("reset",      32'h40,       0, 32'h0,         1, 32'h0,        0, 32'h0,   0,   0, 0, 32'h44,       0);
        step("alloc",      32'h40,       1, 32'h40,        1, 32'h100,      0, 32'h44,  0,   0, 0, 32'h44,       1);
        step("alloc_hit",  32'h40,       0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   1, 1, 32'h100,      0);
        step("tk1",        32'h40,       1, 32'h40,        1, 32'h100,      1, 32'h100, 0,   1, 1, 32'h100,      0);
        step("tk2",        32'h40,       1, 32'h40,        1, 32'h100,      1, 32'h100, 0,   1, 1, 32'h100,      0);
        step("tk3",        32'h40,       1, 32'h40,        1, 32'h100,      1, 32'h100, 0,   1, 1, 32'h100,      0);
        step("nt1",        32'h40,       1, 32'h40,        0, 32'h0,        1, 32'h100, 0,   1, 1, 32'h100,      1);
        step("nt2",        32'h40,       1, 32'h40,        0, 32'h0,        1, 32'h100, 0,   1, 1, 32'h100,      1);
        step("hyst_nt",    32'h40,       0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   1, 0, 32'h44,       0);
        step("retake",     32'h40,       1, 32'h40,        1, 32'h100,      0, 32'h44,  0,   1, 0, 32'h44,       1);
        step("tgt_mis",    32'h40,       1, 32'h40,        1, 32'h180,      1, 32'h100, 0,   1, 1, 32'h100,      1);
        step("tgt_new",    32'h40,       0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   1, 1, 32'h180,      0);
        step("alias_miss", 32'h80,       1, 32'h80,        1, 32'h200,      0, 32'h84,  0,   0, 0, 32'h84,       1);
        step("evicted",    32'h40,       0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   0, 0, 32'h44,       0);
        step("alias_hit",  32'h80,       0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   1, 1, 32'h200,      0);
        step("nt_miss",    32'h4,        1, 32'h4,         0, 32'h0,        0, 32'h0,   0,   0, 0, 32'h8,        0);
        step("no_alloc",   32'h4,        0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   0, 0, 32'h8,        0);
        step("wrap",       32'hFFFFFFFC, 0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   0, 0, 32'h0,        0);
        step("pc_lsbs",    32'h83,       0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   1, 1, 32'h200,      0);
        step("clr_upd",    32'h80,       1, 32'h300,       1, 32'h400,      0, 32'h304, 1,   1, 1, 32'h200,      1);
        step("clr_80",     32'h80,       0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   0, 0, 32'h84,       0);
        step("clr_300",    32'h300,      0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   0, 0, 32'h304,      0);
        step("realloc",    32'h80,       1, 32'h80,        1, 32'h210,      0, 32'h84,  0,   0, 0, 32'h84,       1);
        step("realloc_hit",32'h80,       0, 32'h0,         0, 32'h0,        0, 32'h0,   0,   1, 1, 32'h210,      0);

        // Asynchronous reset pulsed between edges while an update is pending
        @(posedge clk);
        #1;
        drive(32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1 reset = 1'b0;
        expect_out("async_rst", 0, 0, 32'h84, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_out("post_rst", 0, 0, 32'h84, 0);
`ifdef BP_PERF_CNT_EN
        chk("perf_branches", perf_branches, 32'h0);
        chk("perf_mispredicts", perf_mispredicts, 32'h0);
        chk("perf_btb_hits", perf_btb_hits, 32'h0);
`endif

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
